// File: rtl/fpu_pkg.sv
// Shared opcode, flag and classification definitions for the FP add/sub pipeline.
package fpu_pkg;

    typedef enum logic [1:0] {
        FPU_ADD = 2'b00,
        FPU_SUB = 2'b01
    } fpu_op_e;

    localparam int unsigned FLG_NV = 4;
    localparam int unsigned FLG_DZ = 3;
    localparam int unsigned FLG_OF = 2;
    localparam int unsigned FLG_UF = 1;
    localparam int unsigned FLG_NX = 0;

    typedef struct packed {
        logic zero;
        logic inf;
        logic qnan;
        logic snan;
    } fp_class_t;

    // Canonical quiet NaN: sign 0, exponent all-ones, only the fraction MSB set.
    function automatic logic [63:0] canon_qnan(input int unsigned exp_w, input int unsigned man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; cnt_o equals WIDTH and zero_o is set when the input is all zeros.
module fp_lzc #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [CW-1:0]    cnt_o,
    output logic             zero_o
);
    logic [WIDTH-1:0] v;
    logic             found;

    always_comb begin
        v     = in_i;
        cnt_o = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!found) begin
                if (v[WIDTH-1]) begin
                    found = 1'b1;
                end else begin
                    cnt_o = cnt_o + CW'(1);
                    v     = v << 1;
                end
            end
        end
    end

    assign zero_o = ~|in_i;

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-754 add/subtract: S1 unpack/classify/swap, S2 align/add,
// S3 normalise/round/pack into the output register. Round to nearest-even.
module fp_addsub_pipe
    import fpu_pkg::*;
#(
    parameter  int unsigned EXP_W = 8,
    parameter  int unsigned MAN_W = 23,
    localparam int unsigned W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] op_a_i,
    input  logic [W-1:0] op_b_i,
    input  logic [1:0]   opcode_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] fpu_o,
    output logic [4:0]   flags_o
);
    localparam int unsigned   SW      = MAN_W + 4;
    localparam int unsigned   SH_MAX  = MAN_W + 3;
    localparam int unsigned   CW      = $clog2(SW + 1);
    localparam int unsigned   XW      = ((EXP_W > CW) ? EXP_W : CW) + 2;
    localparam logic [W-1:0]  QNAN    = W'(canon_qnan(EXP_W, MAN_W));
    localparam logic [W-2:0]  INF_MAG = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
    localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

    logic         adv;
    logic         out_valid_q;
    logic [W-1:0] fpu_q;
    logic [4:0]   flags_q;

    assign adv         = !out_valid_q || out_ready_i;
    assign in_ready_o  = adv;
    assign out_valid_o = out_valid_q;
    assign fpu_o       = fpu_q;
    assign flags_o     = flags_q;

    function automatic fp_class_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        fp_class_t c;
        c.zero = (e == '0);
        c.inf  = (e == '1) && (f == '0);
        c.qnan = (e == '1) && f[MAN_W-1];
        c.snan = (e == '1) && !f[MAN_W-1] && (f != '0);
        return c;
    endfunction

    // ---------------- S1: unpack, classify, order by magnitude ----------------
    logic             a_s, b_s;
    logic [EXP_W-1:0] a_e, b_e;
    logic [MAN_W-1:0] a_f, b_f;
    fp_class_t        ca, cb;
    logic             swap;

    assign a_s  = op_a_i[W-1];
    assign a_e  = op_a_i[W-2:MAN_W];
    assign a_f  = op_a_i[MAN_W-1:0];
    assign b_s  = op_b_i[W-1] ^ (opcode_i == FPU_SUB);
    assign b_e  = op_b_i[W-2:MAN_W];
    assign b_f  = op_b_i[MAN_W-1:0];
    assign ca   = classify(a_e, a_f);
    assign cb   = classify(b_e, b_f);
    assign swap = {b_e, b_f} > {a_e, a_f};

    logic             s1_sign_d, s1_sub_d, s1_sp_d;
    logic [EXP_W-1:0] s1_exp_d, s1_diff_d;
    logic [MAN_W-1:0] s1_fl_d, s1_fs_d;
    logic [W-1:0]     s1_spres_d;
    logic [4:0]       s1_spflg_d;

    always_comb begin
        s1_sign_d  = swap ? b_s : a_s;
        s1_exp_d   = swap ? b_e : a_e;
        s1_fl_d    = swap ? b_f : a_f;
        s1_fs_d    = swap ? a_f : b_f;
        s1_diff_d  = swap ? (b_e - a_e) : (a_e - b_e);
        s1_sub_d   = a_s ^ b_s;
        s1_sp_d    = 1'b1;
        s1_spres_d = QNAN;
        s1_spflg_d = '0;
        // Special outcomes are resolved here and ride the pipe alongside the datapath.
        if (opcode_i[1] || ca.snan || cb.snan || (ca.inf && cb.inf && (a_s ^ b_s))) begin
            s1_spflg_d[FLG_NV] = 1'b1;
        end else if (ca.qnan || cb.qnan) begin
            s1_spres_d = QNAN;
        end else if (ca.inf) begin
            s1_spres_d = {a_s, INF_MAG};
        end else if (cb.inf) begin
            s1_spres_d = {b_s, INF_MAG};
        end else if (ca.zero && cb.zero) begin
            s1_spres_d = {a_s & b_s, {(W-1){1'b0}}};
        end else if (cb.zero) begin
            s1_spres_d = {a_s, a_e, a_f};
        end else if (ca.zero) begin
            s1_spres_d = {b_s, b_e, b_f};
        end else begin
            s1_sp_d = 1'b0;
        end
    end

    logic             s1_valid_q, s1_sign_q, s1_sub_q, s1_sp_q;
    logic [EXP_W-1:0] s1_exp_q, s1_diff_q;
    logic [MAN_W-1:0] s1_fl_q, s1_fs_q;
    logic [W-1:0]     s1_spres_q;
    logic [4:0]       s1_spflg_q;

    // ---------------- S2: align smaller operand, add/subtract ----------------
    logic [SW-1:0] sig_l, sig_s, lost_mask, sig_sh;
    logic [SW:0]   s2_sum_d;
    int unsigned   sh_sat;
    logic          sticky;

    always_comb begin
        sig_l     = {1'b1, s1_fl_q, 3'b000};
        sig_s     = {1'b1, s1_fs_q, 3'b000};
        sh_sat    = (32'(s1_diff_q) > SH_MAX) ? SH_MAX : 32'(s1_diff_q);
        lost_mask = ~({SW{1'b1}} << sh_sat);
        sticky    = |(sig_s & lost_mask);
        sig_sh    = (sig_s >> sh_sat) | SW'(sticky);
        s2_sum_d  = s1_sub_q ? ({1'b0, sig_l} - {1'b0, sig_sh})
                             : ({1'b0, sig_l} + {1'b0, sig_sh});
    end

    logic             s2_valid_q, s2_sign_q, s2_sp_q;
    logic [EXP_W-1:0] s2_exp_q;
    logic [SW:0]      s2_sum_q;
    logic [W-1:0]     s2_spres_q;
    logic [4:0]       s2_spflg_q;

    // ---------------- S3: normalise, round, pack ----------------
    logic [CW-1:0]    lz_cnt;
    logic             lz_zero;

    fp_lzc #(.WIDTH(SW)) u_lzc (
        .in_i   (s2_sum_q[SW-1:0]),
        .cnt_o  (lz_cnt),
        .zero_o (lz_zero)
    );

    logic             carry, g, r, st, inc, ovf, uf, of;
    logic [SW-1:0]    n;
    logic [MAN_W+1:0] mant;
    logic [MAN_W-1:0] frac_r;
    logic [XW-1:0]    e_norm, e_rnd;
    logic [W-1:0]     res_d;
    logic [4:0]       flg_d;

    always_comb begin
        carry = s2_sum_q[SW];
        if (carry) begin
            n    = s2_sum_q[SW:1];
            n[0] = s2_sum_q[1] | s2_sum_q[0];
        end else begin
            n = s2_sum_q[SW-1:0] << lz_cnt;
        end
        e_norm = carry ? (XW'(s2_exp_q) + XW'(1)) : (XW'(s2_exp_q) - XW'(lz_cnt));
        g      = n[2];
        r      = n[1];
        st     = n[0];
        inc    = g && (r || st || n[3]);
        mant   = {1'b0, n[SW-1:3]} + (MAN_W+2)'(inc);
        ovf    = mant[MAN_W+1];
        frac_r = ovf ? mant[MAN_W:1] : mant[MAN_W-1:0];
        e_rnd  = e_norm + XW'(ovf);
        uf     = e_norm[XW-1] || (e_norm == '0);
        of     = !e_rnd[XW-1] && (e_rnd >= EXP_MAX);

        res_d = '0;
        flg_d = '0;
        if (s2_sp_q) begin
            res_d = s2_spres_q;
            flg_d = s2_spflg_q;
        end else if (lz_zero && !carry) begin
            res_d = '0;
        end else if (uf) begin
            res_d         = {s2_sign_q, {(W-1){1'b0}}};
            flg_d[FLG_UF] = 1'b1;
            flg_d[FLG_NX] = 1'b1;
        end else if (of) begin
            res_d         = {s2_sign_q, INF_MAG};
            flg_d[FLG_OF] = 1'b1;
            flg_d[FLG_NX] = 1'b1;
        end else begin
            res_d         = {s2_sign_q, e_rnd[EXP_W-1:0], frac_r};
            flg_d[FLG_NX] = g || r || st;
        end
        flg_d[FLG_DZ] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            fpu_q       <= '0;
            flags_q     <= '0;
        end else if (adv) begin
            s1_valid_q  <= in_valid_i;
            s1_sign_q   <= s1_sign_d;
            s1_sub_q    <= s1_sub_d;
            s1_sp_q     <= s1_sp_d;
            s1_exp_q    <= s1_exp_d;
            s1_diff_q   <= s1_diff_d;
            s1_fl_q     <= s1_fl_d;
            s1_fs_q     <= s1_fs_d;
            s1_spres_q  <= s1_spres_d;
            s1_spflg_q  <= s1_spflg_d;

            s2_valid_q  <= s1_valid_q;
            s2_sign_q   <= s1_sign_q;
            s2_sp_q     <= s1_sp_q;
            s2_exp_q    <= s1_exp_q;
            s2_sum_q    <= s2_sum_d;
            s2_spres_q  <= s1_spres_q;
            s2_spflg_q  <= s1_spflg_q;

            out_valid_q <= s2_valid_q;
            fpu_q       <= res_d;
            flags_q     <= flg_d;
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed self-checking bench for fp_addsub_pipe (single and half precision instances).
module tb_fp_addsub_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, res;
    logic [1:0]  opc;
    logic [4:0]  flg;

    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_a, h_b, h_res;
    logic [1:0]  h_opc;
    logic [4:0]  h_flg;

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_a_i      (a),
        .op_b_i      (b),
        .opcode_i    (opc),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .fpu_o       (res),
        .flags_o     (flg)
    );

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) u_dut_h (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (h_in_valid),
        .in_ready_o  (h_in_ready),
        .op_a_i      (h_a),
        .op_b_i      (h_b),
        .opcode_i    (h_opc),
        .out_valid_o (h_out_valid),
        .out_ready_i (h_out_ready),
        .fpu_o       (h_res),
        .flags_o     (h_flg)
    );

    int n_total = 0;
    int n_pass  = 0;

    localparam logic [31:0] ONE = 32'h3F80_0000;
    // Stream operands k.0 (k=1..8); each is added to 1.0.
    logic [31:0] sa   [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic [31:0] sexp [8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                              32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                          input logic [1:0] op, input logic [31:0] exp_res, input logic [4:0] exp_flg);
        int lat;
        @(negedge clk);
        a = op_a; b = op_b; opc = op; in_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 10);
        check({tag, "_lat"}, lat, 3);
        check({tag, "_res"}, res, exp_res);
        check({tag, "_flg"}, flg, exp_flg);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, sent, got, cyc;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; opc = 2'b00;
        h_in_valid = 1'b0; h_out_ready = 1'b1; h_a = '0; h_b = '0; h_opc = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_ov", out_valid, 0);
        check("reset_res", res, 0);
        check("reset_flg", flg, 0);
        check("reset_rdy", in_ready, 1);
        check("reset_h_ov", h_out_valid, 0);
        check("reset_h_rdy", h_in_ready, 1);

        run_op("add_basic",  32'h3FC00000, 32'h40100000, 2'b00, 32'h40700000, 5'b00000);
        run_op("sub_exact0", 32'h3F800000, 32'h3F800000, 2'b01, 32'h00000000, 5'b00000);
        run_op("sub_ulp",    32'h3F800000, 32'h3F800001, 2'b01, 32'hB4000000, 5'b00000);
        run_op("rnd_tie",    32'h4B800000, 32'h3F800000, 2'b00, 32'h4B800000, 5'b00001);
        run_op("rnd_up",     32'h4B800000, 32'h40400000, 2'b00, 32'h4B800002, 5'b00001);
        run_op("inf_m_inf",  32'h7F800000, 32'hFF800000, 2'b00, 32'h7FC00000, 5'b10000);
        run_op("inf_sub",    32'h7F800000, 32'hFF800000, 2'b01, 32'h7F800000, 5'b00000);
        run_op("snan",       32'h7F800001, 32'h3F800000, 2'b00, 32'h7FC00000, 5'b10000);
        run_op("qnan",       32'h7FC00001, 32'h3F800000, 2'b00, 32'h7FC00000, 5'b00000);
        run_op("bad_op",     32'h3F800000, 32'h3F800000, 2'b10, 32'h7FC00000, 5'b10000);
        run_op("overflow",   32'h7F7FFFFF, 32'h7F7FFFFF, 2'b00, 32'h7F800000, 5'b00101);
        run_op("underflow",  32'h00800001, 32'h00800000, 2'b01, 32'h00000000, 5'b00011);
        run_op("zero_mix",   32'h80000000, 32'h00000000, 2'b00, 32'h00000000, 5'b00000);
        run_op("zero_neg",   32'h80000000, 32'h00000000, 2'b01, 32'h80000000, 5'b00000);
        run_op("zero_a",     32'h00000000, 32'h3F800000, 2'b01, 32'hBF800000, 5'b00000);
        run_op("zero_b",     32'h40400000, 32'h00000000, 2'b00, 32'h40400000, 5'b00000);

        // Half precision instance: 1.0 + 1.0
        @(negedge clk);
        h_a = 16'h3C00; h_b = 16'h3C00; h_opc = 2'b00; h_in_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            h_in_valid = 1'b0;
            lat++;
        end while (!h_out_valid && lat < 10);
        check("half_lat", lat, 3);
        check("half_res", h_res, 16'h4000);
        check("half_flg", h_flg, 5'b00000);

        // Back-to-back stream with a 4-cycle output stall
        sent = 0; got = 0; cyc = 0;
        while (got < 8 && cyc < 60) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc < 8);
            in_valid  = (sent < 8);
            if (sent < 8) begin
                a = sa[sent]; b = ONE; opc = 2'b00;
            end
            #1;
            if (out_valid) begin
                check("stream_res", res, sexp[got]);
                if (!out_ready) check("stall_rdy", in_ready, 0);
                else got++;
            end
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("stream_cnt", got, 8);
        repeat (5) begin
            @(negedge clk); #1;
            check("stream_tail", out_valid, 0);
        end

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = sa[i]; b = ONE; opc = 2'b00;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
        #1;
        check("rst_pre_ov", out_valid, 1);
        @(negedge clk); #1;
        check("rst_ov", out_valid, 0);
        check("rst_res", res, 0);
        rst = 1'b0; out_ready = 1'b1;
        repeat (8) begin
            @(negedge clk); #1;
            check("rst_stale", out_valid, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
